// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard sequencer.
package hazard_ctrl_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Architectural zero register: never written, never a hazard source.
  localparam reg_addr_t REG_X0 = '0;

  typedef enum logic {
    HZ_STATE_RUN    = 1'b0,
    HZ_STATE_REFILL = 1'b1
  } hz_state_e;

  // Front-end control bundle driven toward the IF->ID and decode registers.
  typedef struct packed {
    logic stall_if;
    logic flush_if;
    logic stall_id;
    logic flush_id;
  } pipe_ctrl_t;

  function automatic logic is_reg_x0(input reg_addr_t addr);
    return addr == REG_X0;
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register count of in-flight writes: one increment (issue) and one
// decrement (retire) port, two source-pending read ports and a full check.
module hz_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  input  reg_addr_t chk_addr,
  input  logic      inc_en,
  input  reg_addr_t inc_addr,
  input  logic      dec_en,
  input  reg_addr_t dec_addr,
  output logic      pend1,
  output logic      pend2,
  output logic      full,
  output logic      busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  // Next count per register: issue and retire on the same register cancel,
  // increments saturate, and a retire of an idle register holds at zero.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would otherwise infer a latch.
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (inc_en && inc_addr == reg_addr_t'(i) &&
                   !(dec_en && dec_addr == reg_addr_t'(i))) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_en && dec_addr == reg_addr_t'(i) &&
                   !(inc_en && inc_addr == reg_addr_t'(i))) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Counter bank register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole counter array is reset, unlike a data RAM: a stale
      // count after reset would hold decode on a writer that no longer exists.
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      cnt_q <= cnt_d;
    end
  end

  // Read ports and the aggregate busy flag, all from registered counts.
  always_comb begin
    pend1 = cnt_q[raddr1] != '0;
    pend2 = cnt_q[raddr2] != '0;
    full  = cnt_q[chk_addr] == CNT_MAX;
    busy  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline sequencer: RAW/WAW-full interlock via a write
// scoreboard, redirect refill sequencing and a hazard-stall perf counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter int FLUSH_LEN = 1,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [4:0]        id_raddr1_i,
  input  logic [4:0]        id_raddr2_i,
  input  logic [4:0]        id_waddr_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_waddr_i,
  input  logic              redirect_i,
  input  logic              mem_stall_i,
  output logic              stall_if_o,
  output logic              flush_if_o,
  output logic              stall_id_o,
  output logic              flush_id_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int              FC_W         = 4;
  localparam logic [FC_W-1:0] FC_ONE       = {{(FC_W-1){1'b0}}, 1'b1};
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_LEN - 1);
  localparam logic [PERF_W-1:0] PERF_ONE   = {{(PERF_W-1){1'b0}}, 1'b1};

  hz_state_e       state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [PERF_W-1:0] stall_cnt_q;

  logic       pend1, pend2, wfull, busy;
  logic       raw, waw_full, hz, redirect, issue;
  logic       inc_en, dec_en;
  pipe_ctrl_t ctrl;

  hz_scoreboard #(
    .CNT_W(CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (id_raddr1_i),
    .raddr2   (id_raddr2_i),
    .chk_addr (id_waddr_i),
    .inc_en   (inc_en),
    .inc_addr (id_waddr_i),
    .dec_en   (dec_en),
    .dec_addr (wb_waddr_i),
    .pend1    (pend1),
    .pend2    (pend2),
    .full     (wfull),
    .busy     (busy)
  );

  // Hazard detection from registered counts only; WB is not bypassed.
  always_comb begin
    raw      = id_valid_i &
               ((!is_reg_x0(id_raddr1_i) & pend1) |
                (!is_reg_x0(id_raddr2_i) & pend2));
    waw_full = id_valid_i & !is_reg_x0(id_waddr_i) & wfull;
    hz       = raw | waw_full;
    redirect = redirect_i | (state_q == HZ_STATE_REFILL);
  end

  // Output priority: redirect, then backpressure, then hazard bubble.
  always_comb begin
    ctrl = '0;
    if (redirect) begin
      ctrl.flush_if = 1'b1;
      ctrl.flush_id = 1'b1;
    end else if (mem_stall_i) begin
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
    end else if (hz) begin
      ctrl.stall_if = 1'b1;
      ctrl.flush_id = 1'b1;
    end
  end

  // Scoreboard update requests: issue allocates, WB retires.
  always_comb begin
    issue  = id_valid_i & ~ctrl.flush_id & ~ctrl.stall_id;
    inc_en = issue & !is_reg_x0(id_waddr_i);
    dec_en = wb_valid_i & !is_reg_x0(wb_waddr_i);
  end

  // Refill sequencer next state: hold flush for FLUSH_LEN cycles per redirect.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      HZ_STATE_RUN: begin
        if (redirect_i && FLUSH_LEN > 1) begin
          state_d = HZ_STATE_REFILL;
          fcnt_d  = FLUSH_RELOAD;
        end
      end
      HZ_STATE_REFILL: begin
        if (redirect_i) begin
          fcnt_d = FLUSH_RELOAD;
        end else begin
          fcnt_d = fcnt_q - FC_ONE;
          if (fcnt_q == FC_ONE) state_d = HZ_STATE_RUN;
        end
      end
      default: begin
        state_d = HZ_STATE_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_STATE_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Saturating count of cycles spent in a hazard bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!redirect && !mem_stall_i && hz && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + PERF_ONE;
    end
  end

  assign stall_if_o  = ctrl.stall_if;
  assign flush_if_o  = ctrl.flush_if;
  assign stall_id_o  = ctrl.stall_id;
  assign flush_id_o  = ctrl.flush_id;
  assign busy_o      = busy;
  assign stall_cnt_o = stall_cnt_q;

endmodule
